bcd_seg7_scan: RTL

- Downstream consumer of the 14-bit packed BCD score word {thousands[1:0], hundreds, tens, ones}.
- Latches the word, double-buffers it so a frame is never torn, and time-multiplexes four common-anode 7-segment digits.
- Uses a refresh prescaler, a digit scan counter and an anti-ghost blanking window.
- Sits between the score-to-BCD conversion and the board display pins.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_decode.sv | 27 ++
 rtl/bcd_seg7_scan.sv | 107 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for 7-segment display blocks: segment patterns
// (active low, {g,f,e,d,c,b,a}), digit index type and packed BCD field offsets.
package seg7_pkg;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef logic [1:0] digit_idx_t;

    localparam int ON_LSB = 0;
    localparam int TE_LSB = 4;
    localparam int HU_LSB = 8;
    localparam int TH_LSB = 12;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment decoder; non-decimal
// nibbles render as a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_nibble)
            4'd0: o_seg = SEG_DIGIT[0];
            4'd1: o_seg = SEG_DIGIT[1];
            4'd2: o_seg = SEG_DIGIT[2];
            4'd3: o_seg = SEG_DIGIT[3];
            4'd4: o_seg = SEG_DIGIT[4];
            4'd5: o_seg = SEG_DIGIT[5];
            4'd6: o_seg = SEG_DIGIT[6];
            4'd7: o_seg = SEG_DIGIT[7];
            4'd8: o_seg = SEG_DIGIT[8];
            4'd9: o_seg = SEG_DIGIT[9];
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Four-digit common-anode scanner for a packed BCD score word, double-buffered
// so frames never tear. Define SEG_LZB_EN to enable leading-zero blanking.
module bcd_seg7_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] bcd_in,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_TH = PW'(BLANK_CYC);

    logic [PW-1:0] r_presc;
    digit_idx_t    r_idx;
    logic [13:0]   r_pend;
    logic [13:0]   r_disp;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;

    logic          w_tc;
    logic          w_frame;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg;
    logic          w_lz;

    assign w_tc    = (r_presc == PRESC_TC);
    assign w_frame = w_tc && (r_idx == 2'd3);

    always_comb begin
        w_nib = '0;
        case (r_idx)
            2'd0: w_nib = r_disp[ON_LSB +: 4];
            2'd1: w_nib = r_disp[TE_LSB +: 4];
            2'd2: w_nib = r_disp[HU_LSB +: 4];
            2'd3: w_nib = {2'b00, r_disp[TH_LSB +: 2]};
            default: w_nib = '0;
        endcase
    end

`ifdef SEG_LZB_EN
    // A digit is blanked when it and every higher-order digit are zero; ones never.
    logic w_th_z, w_hu_z, w_te_z;
    assign w_th_z = (r_disp[TH_LSB +: 2] == 2'd0);
    assign w_hu_z = w_th_z && (r_disp[HU_LSB +: 4] == 4'd0);
    assign w_te_z = w_hu_z && (r_disp[TE_LSB +: 4] == 4'd0);

    always_comb begin
        w_lz = 1'b0;
        case (r_idx)
            2'd3: w_lz = w_th_z;
            2'd2: w_lz = w_hu_z;
            2'd1: w_lz = w_te_z;
            default: w_lz = 1'b0;
        endcase
    end
`else
    assign w_lz = 1'b0;
`endif

    seg7_decode u_decode (
        .i_nibble (w_nib),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
            r_pend  <= '0;
            r_disp  <= '0;
            r_an    <= 4'b1111;
            r_seg   <= SEG_BLANK;
        end else begin
            r_presc <= w_tc ? '0 : r_presc + 1'b1;
            if (w_tc)
                r_idx <= r_idx + 2'd1;
            if (load)
                r_pend <= bcd_in;
            // A load landing on the boundary bypasses pending so it is not lost a frame.
            if (w_frame)
                r_disp <= load ? bcd_in : r_pend;
            if (r_presc < BLANK_TH) begin
                r_an  <= 4'b1111;
                r_seg <= SEG_BLANK;
            end else begin
                r_an  <= ~(4'b0001 << r_idx);
                r_seg <= w_lz ? SEG_BLANK : w_seg;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = 1'b1;
    assign frame_done = w_frame;

endmodule
